// File: rtl/pool_row_combiner.sv
// pool_row_combiner
//   Vertical half of a 2x2 max-pool. It takes the stream of horizontal pair
//   maxima and buffers one pooled row of them (FILL). On the next row (EMIT)
//   it combines each buffered value with the vertically adjacent value using
//   the ReLU-max rule and emits one pooled activation per column.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : synchronous active-high reset (has priority over in_valid)
//   in_valid   : in_data is valid this cycle (always consumed)
//   in_data    : sign-magnitude word, bit31 = sign, [30:0] = magnitude
//   out_valid  : one-cycle pulse, out_data/out_col are valid
//   out_data   : pooled activation, always non-negative
//   out_col    : pooled column index of out_data
//   frame_done : pulses together with the last pooled output of a frame
module pool_row_combiner #(
  parameter int OUT_W = 14,
  parameter int OUT_H = 14,
  localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  output logic          out_valid,
  output logic [31:0]   out_data,
  output logic [CW-1:0] out_col,
  output logic          frame_done
);

  typedef enum logic {S_FILL, S_EMIT} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [31:0]   r_rowbuf [OUT_W];

  logic [31:0]   w_top;
  logic [31:0]   w_max;
  logic          w_last_col;
  logic          w_last_row;

  assign w_top      = r_rowbuf[r_col];
  assign w_last_col = (r_col == CW'(OUT_W - 1));
  assign w_last_row = (r_row == RW'(OUT_H - 1));

  // ReLU-max of two sign-magnitude words. Any negative operand (including
  // negative zero) drops out; if both are negative the result clamps to 0.
  // The result therefore never has bit31 set.
  always_comb begin
    w_max = 32'd0;
    unique case ({w_top[31], in_data[31]})
      2'b11:   w_max = 32'd0;
      2'b10:   w_max = in_data;
      2'b01:   w_max = w_top;
      default: w_max = (w_top[30:0] >= in_data[30:0]) ? w_top : in_data;
    endcase
  end

  // Row buffer: written only in FILL and read only in EMIT, so a column is
  // never read and written in the same cycle. Contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && r_state == S_FILL)
      r_rowbuf[r_col] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FILL;
      r_col      <= '0;
      r_row      <= '0;
      out_valid  <= 1'b0;
      out_data   <= 32'd0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      // Pulses default low; out_data/out_col hold between outputs.
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        r_col <= w_last_col ? '0 : r_col + CW'(1);
        unique case (r_state)
          S_FILL: begin
            if (w_last_col) r_state <= S_EMIT;
          end
          S_EMIT: begin
            out_valid <= 1'b1;
            out_data  <= w_max;
            out_col   <= r_col;
            if (w_last_col) begin
              r_state    <= S_FILL;
              r_row      <= w_last_row ? '0 : r_row + RW'(1);
              frame_done <= w_last_row;
            end
          end
          default: r_state <= S_FILL;
        endcase
      end
    end
  end

endmodule

// File: doc/pool_row_combiner.md
Name: pool_row_combiner

Overview:
- Vertical half of the 2x2 max-pool stage in the CNN datapath.
- Sits directly downstream of the pairwise horizontal max unit and consumes its stream of row-wise pair maxima, one 32-bit sign-magnitude word per accepted cycle.
- Buffers one pooled row of horizontal maxima, then combines each with the vertically adjacent value from the next row using the same ReLU-max rule.
- Emits one pooled activation per column pair and pulses a frame-done flag after the last pooled row.

Parameters:
- OUT_W, 14: pooled row width (horizontal maxima per input row pair); range 1..1024.
- OUT_H, 14: pooled rows per frame (input row pairs); range 1..1024.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data carries a horizontal max this cycle.
- in_data  input  32  sign-magnitude value: bit31 sign, [30:0] magnitude.
- out_valid  output  1  single-cycle pulse, out_data holds a pooled value.
- out_data  output  32  pooled activation, non-negative (bit31 always 0).
- out_col  output  CW  pooled column index of out_data; CW = max(1, ceil(log2(OUT_W))).
- frame_done  output  1  single-cycle pulse with the last pooled output of a frame.

Behaviour:
- Reset:
  - Synchronous, active-high; wins over in_valid in the same cycle.
  - out_valid=0, out_data=0, out_col=0, frame_done=0, col=0, row_pair=0, state=FILL.
  - Row buffer contents are don't-care after reset and are never read before being rewritten.
  - Reset mid-frame abandons the partial frame with no output. The next accepted word is column 0 of a new frame.
- State FILL (top row of a pair):
  - Each in_valid writes in_data to rowbuf[col], then col increments.
  - When col==OUT_W-1 is accepted, col returns to 0 and state moves to EMIT.
  - No output in FILL.
- State EMIT (bottom row of a pair):
  - Each in_valid computes m = relumax(rowbuf[col], in_data).
  - Registered on the next clock edge: out_data=m, out_col=col, out_valid=1. Latency is 1 cycle from the accepted input.
  - When col==OUT_W-1 is accepted: col returns to 0, row_pair increments, and state returns to FILL.
  - If that row_pair was OUT_H-1, frame_done pulses in the same cycle as the final out_valid, and row_pair wraps to 0.
- relumax(a,b) rule:
  - Both sign bits set: result 0.
  - Only a negative: result b. Only b negative: result a.
  - Both non-negative: the larger magnitude [30:0]. Equal magnitudes give that value.
  - Negative zero (0x80000000) counts as negative.
- Idle cycles:
  - in_valid=0 leaves col, row_pair and state unchanged, so gaps of any length are legal.
  - out_valid and frame_done are 0 on any cycle not following an accepted EMIT input.
  - out_data and out_col hold their last values.
- Flow control: no backpressure. Every valid input is consumed, and the downstream stage must accept one word per cycle.
- Degenerate sizes:
  - OUT_W=1: FILL and EMIT each last one accepted word.
  - OUT_H=1: frame_done accompanies every pooled row.
- Implementation: row buffer is OUT_W x 32 storage, inferred as a register array or a single-port RAM. Read and write of the same column never occur in the same cycle.

Test Plan:
- OUT_W=2, OUT_H=1; inputs 5, 9, then 7, 3 (back-to-back) -> outputs 7 (col0), 9 (col1), each 1 cycle after its bottom-row input; frame_done with the 9.
- Sign cases, OUT_W=4, OUT_H=1:
  - Top row: 0x80000004, 0x00000006, 0x80000001, 0x00000002.
  - Bottom row: 0x80000008, 0x80000003, 0x00000005, 0x00000002.
  - Expected outputs: 0, 6, 5, 2.
- Gapped input: the first test with 3 idle cycles inserted between every word -> identical outputs and col indices; no spurious out_valid during gaps.
- Frame wrap, OUT_W=2, OUT_H=2; two full frames streamed contiguously -> frame_done exactly twice (after the 4th and 8th pooled output); second frame's col indices restart at 0.
- Reset mid-frame: assert rst after 3 of 4 words of a pair (OUT_W=2), then send 1, 2, 3, 4 -> only outputs 3 (col0), 4 (col1); no output from the abandoned pair.
- Reset priority: rst=1 with in_valid=1 and data 0x7FFFFFFF in EMIT -> next cycle out_valid=0, out_data=0; that input is not counted.
